mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/arb_defs.sv | 18 +
 rtl/arb_rr_pick.sv | 21 ++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_defs.sv
// Shared constants for the two-master memory arbiter: FSM encoding,
// default burst limit and the data-memory / MMIO address boundary.
package arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam int unsigned MAX_BURST_DEF = 8;
    localparam logic [31:0] MMIO_BASE_DEF = 32'h4000_0000;

    function automatic logic is_mmio(input logic [31:0] addr, input logic [31:0] base);
        return addr >= base;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin choice: a lone requester wins; on a tie the master
// that was not served last (ptr = last owner) wins.
module arb_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic valid,
    output logic pick
);

    always_comb begin
        valid = req0 | req1;
        pick  = 1'b0;
        if (req0 && req1) begin
            pick = ~ptr;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single data-memory port between a CPU (m0) and a DMA/loader (m1),
// with locked bursts bounded by MAX_BURST and MMIO-range error reporting.
module mem_arbiter
    import arb_defs::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEF,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    arb_state_t    state, state_next;
    logic          rr_ptr, rr_ptr_next;
    logic [CW-1:0] burst_cnt, burst_cnt_next;
    logic          pick_valid, pick;

    logic          own_req, own_lock, oth_req;
    arb_state_t    oth_state;

    logic          beat0, beat1, mmio0, mmio1;
    logic          cur_we, cur_mmio;
    logic          rd0, rd1;

    arb_rr_pick u_pick (
        .req0  (m0_req),
        .req1  (m1_req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .pick  (pick)
    );

    assign mmio0 = is_mmio(m0_addr, MMIO_BASE);
    assign mmio1 = is_mmio(m1_addr, MMIO_BASE);
    assign beat0 = m0_gnt & m0_req;
    assign beat1 = m1_gnt & m1_req;
    assign rd0   = beat0 & ~m0_we;
    assign rd1   = beat1 & ~m1_we;

    assign cur_we    = m1_gnt ? m1_we    : m0_we;
    assign cur_mmio  = m1_gnt ? mmio1    : mmio0;
    assign mem_addr  = m1_gnt ? m1_addr  : m0_addr;
    assign mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
    assign mem_read  = (beat0 | beat1) & ~cur_we & ~cur_mmio;
    assign mem_write = (beat0 | beat1) &  cur_we & ~cur_mmio;

    // Owner/other view lets OWN0 and OWN1 share one set of transition rules.
    always_comb begin
        own_req   = 1'b0;
        own_lock  = 1'b0;
        oth_req   = 1'b0;
        oth_state = ST_IDLE;
        if (state == ST_OWN0) begin
            own_req   = m0_req;
            own_lock  = m0_lock;
            oth_req   = m1_req;
            oth_state = ST_OWN1;
        end else if (state == ST_OWN1) begin
            own_req   = m1_req;
            own_lock  = m1_lock;
            oth_req   = m0_req;
            oth_state = ST_OWN0;
        end
    end

    always_comb begin
        state_next     = state;
        burst_cnt_next = burst_cnt;
        rr_ptr_next    = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = pick ? ST_OWN1 : ST_OWN0;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!own_req) begin
                    state_next = oth_req ? oth_state : ST_IDLE;
                end else if (oth_req) begin
                    if (!own_lock || burst_cnt == LAST_BEAT) begin
                        state_next = oth_state;
                    end else begin
                        burst_cnt_next = burst_cnt + CW'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (!oth_req || state_next != state) begin
            burst_cnt_next = '0;
        end
        if (state_next == ST_OWN0 && state != ST_OWN0) begin
            rr_ptr_next = 1'b0;
        end else if (state_next == ST_OWN1 && state != ST_OWN1) begin
            rr_ptr_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= 1'b1;
            burst_cnt <= '0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
        end else begin
            state     <= state_next;
            rr_ptr    <= rr_ptr_next;
            burst_cnt <= burst_cnt_next;
            m0_gnt    <= (state_next == ST_OWN0);
            m1_gnt    <= (state_next == ST_OWN1);
        end
    end

    // MMIO reads still complete, but return zero instead of memory data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m_err     <= '0;
        end else begin
            m0_rvalid <= rd0;
            m1_rvalid <= rd1;
            m_err     <= {beat1 & mmio1, beat0 & mmio0};
            if (rd0) begin
                m0_rdata <= mmio0 ? '0 : mem_rdata;
            end
            if (rd1) begin
                m1_rdata <= mmio1 ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter plus a bounded random
// fairness / mutual-exclusion run.
module tb_mem_arbiter;

    localparam int unsigned MAXB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m_err;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_BURST(MAXB), .MMIO_BASE(32'h4000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_rvalid (m1_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_rdata  (m1_rdata),
        .m_err     (m_err),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    int unsigned beats;
    int unsigned w0, w1, max_wait;
    int unsigned viol_g, viol_m, viol_en;
    logic        exp_rd, exp_wr;

    initial begin
        // Reset state
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        check("rst_gnt",    {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        check("rst_err",    {30'd0, m_err}, 32'd0);
        check("rst_rdata0", m0_rdata, 32'd0);
        check("rst_rdata1", m1_rdata, 32'd0);
        reset = 1'b1;

        // Single m0 read
        m0_req = 1; m0_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
        #1 check("rd_idle_memread", {31'd0, mem_read}, 32'd0);
        tick();
        check("rd_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        check("rd_memread", {31'd0, mem_read}, 32'd1);
        check("rd_addr", mem_addr, 32'h10);
        check("rd_no_early_rvalid", {31'd0, m0_rvalid}, 32'd0);
        tick();
        check("rd_rvalid", {31'd0, m0_rvalid}, 32'd1);
        check("rd_rdata", m0_rdata, 32'hDEADBEEF);
        m0_req = 0; mem_rdata = 32'h12345678;
        #1 check("rd_noreq_memread", {31'd0, mem_read}, 32'd0);
        tick();
        check("rd_rvalid_pulse", {31'd0, m0_rvalid}, 32'd0);
        check("rd_rdata_hold", m0_rdata, 32'hDEADBEEF);
        check("rd_release", {30'd0, m1_gnt, m0_gnt}, 32'd0);

        // Tie after reset, then handoff with no idle gap
        do_reset();
        m0_req = 1; m1_req = 1; m0_addr = 32'h20; m1_addr = 32'h30;
        tick();
        check("tie_first", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        m0_lock = 1;
        #1 check("tie_addr0", mem_addr, 32'h20);
        tick();
        check("tie_lock_hold", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        m0_req = 0; m0_lock = 0;
        #1 check("tie_drop_memread", {31'd0, mem_read}, 32'd0);
        tick();
        check("tie_handoff", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        check("tie_addr1", mem_addr, 32'h30);
        check("tie_memread1", {31'd0, mem_read}, 32'd1);

        // m1 locked burst against waiting m0
        do_reset();
        m1_req = 1; m1_lock = 1; m1_we = 1; m1_addr = 32'h100; m1_wdata = 32'hA5A5_0001;
        tick();
        check("burst_m1_own", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        check("burst_wdata", mem_wdata, 32'hA5A5_0001);
        check("burst_memwrite", {30'd0, mem_write, mem_read}, 32'd2);
        m0_req = 1; m0_addr = 32'h200;
        beats = 0;
        for (int i = 0; i < 20; i++) begin
            if (m0_gnt) break;
            if (m1_gnt && m1_req) beats++;
            tick();
        end
        check("burst_beats", beats, MAXB);
        check("burst_m0_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        check("burst_m0_addr", mem_addr, 32'h200);
        tick();
        check("burst_return", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        beats = 0;
        for (int i = 0; i < 20; i++) begin
            if (m0_gnt) break;
            if (m1_gnt && m1_req) beats++;
            tick();
        end
        check("burst_beats_again", beats, MAXB);

        // Unlocked contention alternates every beat
        do_reset();
        m0_req = 1; m1_req = 1;
        tick();
        check("alt_0", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        tick();
        check("alt_1", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        tick();
        check("alt_2", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        tick();
        check("alt_3", {30'd0, m1_gnt, m0_gnt}, 32'd2);

        // MMIO write and read, and the boundary just below MMIO_BASE
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 32'h4000_0004; m0_wdata = 32'h5555_AAAA;
        tick();
        check("mmio_wr_memwrite", {30'd0, mem_write, mem_read}, 32'd0);
        check("mmio_wr_err_early", {30'd0, m_err}, 32'd0);
        tick();
        check("mmio_wr_err", {30'd0, m_err}, 32'd1);
        check("mmio_wr_owned", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        m0_addr = 32'h4;
        #1 check("mmio_wr_normal", {31'd0, mem_write}, 32'd1);
        tick();
        check("mmio_wr_err_pulse", {30'd0, m_err}, 32'd0);
        m0_req = 0; m1_req = 1; m1_addr = 32'h7FFF_0000; mem_rdata = 32'hCAFE_F00D;
        tick();
        check("mmio_rd_own", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        check("mmio_rd_memread", {31'd0, mem_read}, 32'd0);
        tick();
        check("mmio_rd_rvalid", {31'd0, m1_rvalid}, 32'd1);
        check("mmio_rd_rdata", m1_rdata, 32'd0);
        check("mmio_rd_err", {30'd0, m_err}, 32'd2);
        m1_addr = 32'h3FFF_FFFC;
        #1 check("below_base_memread", {31'd0, mem_read}, 32'd1);
        tick();
        check("below_base_err", {30'd0, m_err}, 32'd0);
        check("below_base_rdata", m1_rdata, 32'hCAFE_F00D);

        // Reset asserted during an m1 read beat
        do_reset();
        m1_req = 1; m1_addr = 32'h50; mem_rdata = 32'h1111_1111;
        tick();
        check("rstmid_beat", {30'd0, mem_read, m1_gnt}, 32'd3);
        #1 reset = 1'b0;
        #1;
        check("rstmid_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("rstmid_mem", {30'd0, mem_write, mem_read}, 32'd0);
        check("rstmid_rvalid", {31'd0, m1_rvalid}, 32'd0);
        tick();
        m0_req = 1;
        reset = 1'b1;
        tick();
        check("rstmid_tie", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        check("rstmid_no_rvalid", {31'd0, m1_rvalid}, 32'd0);

        // Random traffic: exclusivity, enable decode and bounded waiting
        do_reset();
        w0 = 0; w1 = 0; max_wait = 0; viol_g = 0; viol_m = 0; viol_en = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!(m0_req && !m0_gnt)) m0_req = 1'($urandom_range(0, 1));
            if (!(m1_req && !m1_gnt)) m1_req = 1'($urandom_range(0, 1));
            m0_lock = 1'($urandom_range(0, 1));
            m1_lock = 1'($urandom_range(0, 1));
            m0_we   = 1'($urandom_range(0, 1));
            m1_we   = 1'($urandom_range(0, 1));
            m0_addr = ($urandom_range(0, 7) == 0) ? 32'h4000_0000 + $urandom_range(0, 255) : $urandom_range(0, 4095);
            m1_addr = ($urandom_range(0, 7) == 0) ? 32'h4000_0000 + $urandom_range(0, 255) : $urandom_range(0, 4095);
            mem_rdata = $urandom;
            #1;
            if (m0_gnt && m1_gnt) viol_g++;
            if (mem_read && mem_write) viol_m++;
            exp_rd = (m0_gnt && m0_req && !m0_we && m0_addr < 32'h4000_0000) ||
                     (m1_gnt && m1_req && !m1_we && m1_addr < 32'h4000_0000);
            exp_wr = (m0_gnt && m0_req && m0_we && m0_addr < 32'h4000_0000) ||
                     (m1_gnt && m1_req && m1_we && m1_addr < 32'h4000_0000);
            if (mem_read !== exp_rd || mem_write !== exp_wr) viol_en++;
            w0 = (m0_req && !m0_gnt) ? w0 + 1 : 0;
            w1 = (m1_req && !m1_gnt) ? w1 + 1 : 0;
            if (w0 > max_wait) max_wait = w0;
            if (w1 > max_wait) max_wait = w1;
            tick();
        end
        check("rand_gnt_excl", viol_g, 32'd0);
        check("rand_mem_excl", viol_m, 32'd0);
        check("rand_enables", viol_en, 32'd0);
        check("rand_wait_bound", {31'd0, max_wait <= MAXB + 2}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
